// File: rtl/encoder_8_3_rr.sv
// Registered 8-to-3 encoder with round-robin or fixed priority over a valid/ready handshake.
// One selection register stage; out_onehot and any_req are decoded combinationally.
module encoder_8_3_rr #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [2:0] out_idx,
    output logic [7:0] out_onehot,
    output logic       any_req
);

    logic [2:0] ptr;
    logic [2:0] start;
    logic [3:0] pick;
    logic       accept;
    logic       load;

    // Scan r from position s upward, wrapping 7->0. Result is {found, index}.
    // Descending loop so the candidate nearest to s is written last and wins.
    function automatic logic [3:0] first_from(input logic [7:0] r, input logic [2:0] s);
        logic [2:0] cand;
        logic [3:0] res;
        res = 4'b0;
        for (int i = 7; i >= 0; i--) begin
            cand = s + 3'(i);
            if (r[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

    assign accept = out_valid & out_ready;
    assign load   = ~out_valid | accept;

    // Search resumes just past an index accepted this cycle so a new grant loads with no bubble.
    always_comb begin
        start = 3'd0;
        if (ROUND_ROBIN) start = accept ? (out_idx + 3'd1) : ptr;
    end

    assign pick = first_from(req, start);

    // Selection register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_idx   <= 3'd0;
            ptr       <= 3'd0;
        end else begin
            if (load) begin
                out_valid <= pick[3];
                if (pick[3]) out_idx <= pick[2:0];
            end
            if (accept) ptr <= out_idx + 3'd1;
        end
    end

    assign out_onehot = out_valid ? (8'b1 << out_idx) : 8'b0;
    assign any_req    = |req;

endmodule

// File: doc/encoder_8_3_rr.md
Name: encoder_8_3_rr

Overview:
Registered 8-to-3 round-robin encoder. It is the inverse of the team's 3-to-8 decoder. It takes eight level-sensitive request lines and emits the 3-bit index of one selected request, plus a matching one-hot vector, over a valid/ready handshake. It sits between request sources (cache miss sources, writeback slots) and a consumer that takes one encoded index per cycle.

Parameters:
ROUND_ROBIN, 1, 1 = rotating priority starting after the last accepted index; 0 = fixed priority, lowest index wins.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous reset, active-low
req  input  8  request lines, level-sensitive, bit i = source i
out_ready  input  1  consumer accepts out_idx this cycle
out_valid  output  1  out_idx/out_onehot hold a selected request
out_idx  output  3  encoded index of selected request
out_onehot  output  8  one-hot decode of out_idx; all-zero when out_valid=0
any_req  output  1  combinational OR of req, unregistered

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - out_valid=0, out_idx=0, out_onehot=0, ptr=0.
  - Reset mid-handshake discards the held grant; no acceptance is reported.
- Internal state:
  - ptr[2:0] = search start position.
  - Output register holding out_valid and out_idx.
- Load condition: load = ~out_valid | (out_valid & out_ready).
- Search start:
  - ROUND_ROBIN=1: start = (out_valid & out_ready) ? out_idx+1 (mod 8) : ptr.
  - ROUND_ROBIN=0: start = 0 always.
- Selection: first set bit of req scanning start, start+1, ... wrapping 7->0. Arithmetic is 3-bit modulo 8.
- On each edge where load=1:
  - req!=0: out_valid<=1, out_idx<=selected index.
  - req==0: out_valid<=0, out_idx holds its previous value.
- When load=0 (valid & ~ready), out_valid and out_idx are held stable regardless of req changes. A grant stays sticky even if its req bit drops.
- ptr update: on handshake (out_valid & out_ready), ptr<=out_idx+1 (mod 8). Otherwise ptr holds.
- Latency: a request present at edge N with the output register free appears with out_valid=1 after edge N (1 cycle).
- Throughput: one index per cycle when out_ready is held high and requests persist.
- Simultaneous accept and new load in the same cycle is allowed. The new selection uses the post-accept start, so no bubble is inserted.
- Fairness (ROUND_ROBIN=1): with k persistent requesters and out_ready=1, each is granted once per k accepted grants.
- out_onehot = decode(out_idx) gated by out_valid: bit out_idx set iff out_valid=1.
- out_ready while out_valid=0 is ignored; ptr does not change.
- Wrap-around: index 7 accepted -> next search starts at 0.
- No X propagation: out_idx has a defined value at all times after reset.

Test Plan:
1. Reset with req=8'h00, then release -> out_valid=0, out_onehot=8'h00, any_req=0 for 5 cycles.
2. req=8'b0010_0100, out_ready=1, ROUND_ROBIN=1 -> accepted sequence out_idx=2,5,2,5. out_onehot alternates 8'h04/8'h20. out_valid stays high with no bubbles.
3. req=8'h81, first grant idx=0, then out_ready=0 for 4 cycles while req changes to 8'h80 -> out_idx stays 0 (sticky). Raise out_ready -> 0 accepted, next out_idx=7, then 0 once req returns to 8'h81 (wrap 7->0 checked).
4. ROUND_ROBIN=0, req=8'hFF, out_ready=1 -> out_idx=0 every cycle. Clear bit 0 (req=8'hFE) -> out_idx=1.
5. Single pulse req=8'h10 for one cycle, out_ready=0 -> out_valid=1, out_idx=4 held until out_ready=1. After acceptance with req=0, out_valid=0 the next cycle.
6. Assert rst_n=0 asynchronously mid-cycle while out_valid=1, out_idx=6 -> outputs clear immediately, before the next edge. After release with req=8'hFF -> first out_idx=0 (ptr reset).
